thiele_colouring_verifier: RTL

Sequential certificate checker for 3-colouring results emitted by the autonomous solver. It captures an adjacency matrix and a packed 2-bit colouring, then audits them. It checks every node's colour code and self-loop bit, then every unordered node pair, one check per cycle. It reports pass/fail, the first offending node pair, and its own verification µ-ledger. It sits downstream of the solver so claimed colourings are independently re-verified in hardware.

---
 rtl/thiele_colouring_verifier.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/thiele_colouring_verifier.sv
// Sequential 3-colouring certificate checker.
// Captures an adjacency matrix and a packed 2-bit colouring, audits every node
// (colour code, self-loop), then every unordered pair u<v, one check per cycle.
// Reports pass/fail, the first offending pair and a verification mu-ledger.
module thiele_colouring_verifier #(
   parameter int unsigned NODES               = 9,
   parameter int unsigned MU_PRECISION        = 16,
   parameter logic [31:0] CHECK_QUESTION_BITS = 32'd1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [NODES*NODES-1:0]   adjacency,
   input  logic [2*NODES-1:0]       colouring,
   output logic                     busy,
   output logic                     done,
   output logic                     valid,
   output logic [1:0]               error_code,
   output logic [7:0]               bad_u,
   output logic [7:0]               bad_v,
   output logic                     asymmetric_seen,
   output logic [15:0]              edges_checked,
   output logic [31:0]              mu_question_bits,
   output logic [31:0]              mu_total_q16
);

   localparam int unsigned AW     = (NODES * NODES > 1) ? $clog2(NODES * NODES) : 1;
   localparam int unsigned CW     = $clog2(2 * NODES);
   localparam logic [7:0]  LAST_N = 8'(NODES - 1);
   localparam logic [7:0]  LAST_U = 8'(NODES - 2);

   localparam logic [1:0] ERR_OK         = 2'd0;
   localparam logic [1:0] ERR_BAD_COLOUR = 2'd1;
   localparam logic [1:0] ERR_CONFLICT   = 2'd2;
   localparam logic [1:0] ERR_SELF_LOOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      SCAN_NODES,
      SCAN_PAIRS,
      FINISHED
   } state_t;

   state_t                 state;
   state_t                 state_next;

   logic [NODES*NODES-1:0] adj_q;
   logic [2*NODES-1:0]     col_q;
   logic [7:0]             idx_u;
   logic [7:0]             idx_v;

   logic [AW-1:0]          diag_idx;
   logic [AW-1:0]          uv_idx;
   logic [AW-1:0]          vu_idx;
   logic [CW-1:0]          cu_idx;
   logic [CW-1:0]          cv_idx;
   logic [1:0]             col_u;
   logic [1:0]             col_v;
   logic                   bad_colour;
   logic                   self_loop;
   logic                   bit_uv;
   logic                   bit_vu;
   logic                   edge_present;
   logic                   colour_clash;
   logic                   last_node;
   logic                   last_pair;
   logic [31:0]            mu_next;

   // Look up the captured matrix/colouring for the current node or pair.
   always_comb begin
      diag_idx     = AW'(idx_u * NODES + idx_u);
      uv_idx       = AW'(idx_u * NODES + idx_v);
      vu_idx       = AW'(idx_v * NODES + idx_u);
      cu_idx       = CW'(2 * idx_u);
      cv_idx       = CW'(2 * idx_v);
      col_u        = col_q[cu_idx +: 2];
      col_v        = col_q[cv_idx +: 2];
      bad_colour   = (col_u == 2'd3);
      self_loop    = adj_q[diag_idx];
      bit_uv       = adj_q[uv_idx];
      bit_vu       = adj_q[vu_idx];
      edge_present = bit_uv | bit_vu;
      colour_clash = (col_u == col_v);
      last_node    = (idx_u == LAST_N);
      last_pair    = (idx_u == LAST_U) && (idx_v == LAST_N);
      mu_next      = mu_question_bits + CHECK_QUESTION_BITS;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection: scan nodes, then pairs, abort to FINISHED on the first error.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = SCAN_NODES;
         end
         SCAN_NODES: begin
            if (bad_colour || self_loop) state_next = FINISHED;
            else if (last_node)          state_next = SCAN_PAIRS;
         end
         SCAN_PAIRS: begin
            if ((edge_present && colour_clash) || last_pair) state_next = FINISHED;
         end
         FINISHED: begin
            if (!start) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture, index walk, ledger accumulation and result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         adj_q            <= '0;
         col_q            <= '0;
         idx_u            <= '0;
         idx_v            <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         valid            <= 1'b0;
         error_code       <= ERR_OK;
         bad_u            <= '0;
         bad_v            <= '0;
         asymmetric_seen  <= 1'b0;
         edges_checked    <= '0;
         mu_question_bits <= '0;
         mu_total_q16     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  adj_q            <= adjacency;
                  col_q            <= colouring;
                  idx_u            <= '0;
                  idx_v            <= '0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  error_code       <= ERR_OK;
                  bad_u            <= '0;
                  bad_v            <= '0;
                  asymmetric_seen  <= 1'b0;
                  edges_checked    <= '0;
                  mu_question_bits <= '0;
                  mu_total_q16     <= '0;
               end
            end
            SCAN_NODES: begin
               if (bad_colour) begin
                  error_code <= ERR_BAD_COLOUR;
                  bad_u      <= idx_u;
                  bad_v      <= idx_u;
                  valid      <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else if (self_loop) begin
                  error_code <= ERR_SELF_LOOP;
                  bad_u      <= idx_u;
                  bad_v      <= idx_u;
                  valid      <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else if (last_node) begin
                  idx_u <= '0;
                  idx_v <= 8'd1;
               end else begin
                  idx_u <= idx_u + 8'd1;
               end
            end
            SCAN_PAIRS: begin
               if (bit_uv ^ bit_vu) asymmetric_seen <= 1'b1;
               if (edge_present) begin
                  if (edges_checked != 16'hFFFF) edges_checked <= edges_checked + 16'd1;
                  mu_question_bits <= mu_next;
                  mu_total_q16     <= mu_next << MU_PRECISION;
               end
               if (edge_present && colour_clash) begin
                  error_code <= ERR_CONFLICT;
                  bad_u      <= idx_u;
                  bad_v      <= idx_v;
                  valid      <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else if (last_pair) begin
                  error_code <= ERR_OK;
                  valid      <= 1'b1;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else if (idx_v == LAST_N) begin
                  idx_u <= idx_u + 8'd1;
                  idx_v <= idx_u + 8'd2;
               end else begin
                  idx_v <= idx_v + 8'd1;
               end
            end
            FINISHED: begin
               if (!start) done <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule
